// File: rtl/led_pattern_engine.sv
// LED pattern engine: a prescaled step tick advances a WIDTH-bit LED pattern in
// one of four modes (rotate, bounce, fill/drain, blink). The engine raises a step
// pulse on every advance and a wrap pulse whenever the pattern reaches an end.
module led_pattern_engine #(
    parameter int WIDTH    = 16,
    parameter int DIV_BITS = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [1:0]       spd,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             wrap
);
    localparam int LVL_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MSB_HOT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_HOT = WIDTH'(1);

    typedef enum logic [1:0] {M_ROTATE, M_BOUNCE, M_FILL, M_BLINK} mode_e;

    mode_e                mode_q, mode_d;
    logic [DIV_BITS-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]     led_q, led_d;
    logic                 bdir_q, bdir_d;
    logic [LVL_W-1:0]     lvl_q, lvl_d;
    logic                 fdn_q, fdn_d;     // fill phase: 0 = filling up, 1 = draining
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;

    logic [DIV_BITS-1:0]  div_mask;
    logic                 tick;
    logic [LVL_W-1:0]     lvl_nxt;
    logic [WIDTH-1:0]     fill_pat;

    // Step tick: the low (DIV_BITS-spd) counter bits are all ones. A speed change
    // only moves the mask, so it takes effect on the next matching count.
    always_comb begin
        div_mask = {DIV_BITS{1'b1}} >> spd;
        tick     = en && ((cnt_q & div_mask) == div_mask);
    end

    // Fill level after this step and the bar it produces; dir is sampled live.
    always_comb begin
        lvl_nxt  = fdn_q ? (lvl_q - LVL_W'(1)) : (lvl_q + LVL_W'(1));
        fill_pat = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fill_pat[i] = dir ? (i < int'(lvl_nxt)) : (i >= WIDTH - int'(lvl_nxt));
        end
    end

    // Next state: a mode change reloads (and beats a coincident tick), otherwise a tick advances the pattern.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        led_d  = led_q;
        bdir_d = bdir_q;
        lvl_d  = lvl_q;
        fdn_d  = fdn_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (mode_e'(mode) != mode_q) begin
            mode_d = mode_e'(mode);
            cnt_d  = '0;
            bdir_d = dir;
            lvl_d  = '0;
            fdn_d  = 1'b0;
            led_d  = mode[1] ? '0 : MSB_HOT;
        end else if (en) begin
            cnt_d = cnt_q + DIV_BITS'(1);
            if (tick) begin
                step_d = 1'b1;
                case (mode_q)
                    M_ROTATE: begin
                        if (led_q == '0) begin
                            led_d = MSB_HOT;          // recover from a corrupted blank pattern
                        end else if (dir) begin
                            if (led_q[WIDTH-1]) begin
                                led_d  = LSB_HOT;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d  = MSB_HOT;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    M_BOUNCE: begin
                        if (led_q == '0) begin
                            led_d = MSB_HOT;
                        end else if (bdir_q) begin
                            if (led_q[WIDTH-1]) begin
                                bdir_d = 1'b0;
                                led_d  = led_q >> 1;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                bdir_d = 1'b1;
                                led_d  = led_q << 1;
                                wrap_d = 1'b1;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    M_FILL: begin
                        lvl_d = lvl_nxt;
                        led_d = fill_pat;
                        if ((!fdn_q && lvl_nxt == LVL_W'(WIDTH)) || (fdn_q && lvl_nxt == '0)) begin
                            fdn_d  = ~fdn_q;
                            wrap_d = 1'b1;
                        end
                    end
                    M_BLINK: begin
                        led_d  = ~led_q;
                        wrap_d = (~led_q == '1);
                    end
                endcase
            end
        end
    end

    // State register; reset is asynchronous and clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= M_ROTATE;
            cnt_q  <= '0;
            led_q  <= MSB_HOT;
            bdir_q <= 1'b0;
            lvl_q  <= '0;
            fdn_q  <= 1'b0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            bdir_q <= bdir_d;
            lvl_q  <= lvl_d;
            fdn_q  <= fdn_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule
